// File: rtl/blood_pkg.sv
// Shared constants, FSM state type and width helper for the blood-splatter overlay.
package blood_pkg;
  localparam int SPR_SIZE = 64;
  localparam int COLOR_W  = 12;
  localparam logic [COLOR_W-1:0] TRANSPARENT = 12'h000;

  typedef enum logic [1:0] {IDLE, ARMED, PLAY} state_e;

  // Counter width for n values; never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/blood_anim_ctrl.sv
// Animation sequencer: hit latch, frame/hold counters, all stepped only on frame_tick or trigger.
module blood_anim_ctrl
  import blood_pkg::*;
#(
  parameter  int FRAMES     = 8,
  parameter  int FRAME_HOLD = 4,
  localparam int FW         = idx_w(FRAMES),
  localparam int HW         = idx_w(FRAME_HOLD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          trigger,
  input  logic          frame_tick,
  input  logic [9:0]    hit_x,
  input  logic [9:0]    hit_y,
  output logic [FW-1:0] frame,
  output logic [9:0]    px,
  output logic [9:0]    py,
  output logic          playing,
  output logic          busy
);
  state_e        state, state_nx;
  logic [FW-1:0] frame_nx;
  logic [HW-1:0] hold, hold_nx;
  logic [9:0]    px_nx, py_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      frame <= '0;
      hold  <= '0;
      px    <= '0;
      py    <= '0;
    end else begin
      state <= state_nx;
      frame <= frame_nx;
      hold  <= hold_nx;
      px    <= px_nx;
      py    <= py_nx;
    end
  end

  // A trigger always wins over a coincident frame_tick.
  always_comb begin
    state_nx = state;
    frame_nx = frame;
    hold_nx  = hold;
    px_nx    = px;
    py_nx    = py;
    if (trigger) begin
      state_nx = ARMED;
      frame_nx = '0;
      hold_nx  = '0;
      px_nx    = hit_x;
      py_nx    = hit_y;
    end else if (frame_tick) begin
      case (state)
        ARMED: begin
          state_nx = PLAY;
          frame_nx = '0;
          hold_nx  = '0;
        end
        PLAY: begin
          if (hold == HW'(FRAME_HOLD - 1)) begin
            hold_nx = '0;
            if (frame == FW'(FRAMES - 1)) begin
              state_nx = IDLE;
              frame_nx = '0;
            end else begin
              frame_nx = frame + 1'b1;
            end
          end else begin
            hold_nx = hold + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign playing = (state == PLAY);
  assign busy    = (state != IDLE);
endmodule

// File: rtl/blood_sprite_engine.sv
// Splatter overlay: box test and ROM addressing, then a 2-stage pipeline aligned to the ROM's registered read.
module blood_sprite_engine
  import blood_pkg::*;
#(
  parameter int FRAMES     = 8,
  parameter int FRAME_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      video_on,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic                      frame_tick,
  input  logic                      trigger,
  input  logic [9:0]                hit_x,
  input  logic [9:0]                hit_y,
  output logic [5:0]                rom_row,
  output logic [5:0]                rom_col,
  input  logic [FRAMES*COLOR_W-1:0] rom_data,
  output logic [COLOR_W-1:0]        rgb_out,
  output logic                      blood_on,
  output logic                      busy
);
  localparam int FW = idx_w(FRAMES);

  logic [FW-1:0]      frame;
  logic [9:0]         px, py;
  logic               playing;
  logic               in_box;
  logic [10:0]        x_w, y_w, px_w, py_w;
  logic               s1_vis;
  logic [FW-1:0]      s1_frame;
  logic [COLOR_W-1:0] sel;
  logic               opaque;

  blood_anim_ctrl #(.FRAMES(FRAMES), .FRAME_HOLD(FRAME_HOLD)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .trigger    (trigger),
    .frame_tick (frame_tick),
    .hit_x      (hit_x),
    .hit_y      (hit_y),
    .frame      (frame),
    .px         (px),
    .py         (py),
    .playing    (playing),
    .busy       (busy)
  );

  // 11-bit compare so a box near the right/bottom edge never wraps to 0.
  assign x_w  = {1'b0, x};
  assign y_w  = {1'b0, y};
  assign px_w = {1'b0, px};
  assign py_w = {1'b0, py};
  assign in_box = busy
               && (x_w >= px_w) && (x_w < px_w + 11'(SPR_SIZE))
               && (y_w >= py_w) && (y_w < py_w + 11'(SPR_SIZE));

  assign rom_col = in_box ? (x[5:0] - px[5:0]) : 6'd0;
  assign rom_row = in_box ? (y[5:0] - py[5:0]) : 6'd0;

  // Stage 1 lines up with the ROM's internal address register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vis   <= 1'b0;
      s1_frame <= '0;
    end else begin
      s1_vis   <= in_box & video_on & playing;
      s1_frame <= frame;
    end
  end

  always_comb begin
    sel = TRANSPARENT;
    for (int k = 0; k < FRAMES; k++)
      if (s1_frame == FW'(k)) sel = rom_data[k*COLOR_W +: COLOR_W];
  end

  assign opaque = s1_vis && (sel != TRANSPARENT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out  <= TRANSPARENT;
      blood_on <= 1'b0;
    end else begin
      rgb_out  <= opaque ? sel : TRANSPARENT;
      blood_on <= opaque;
    end
  end
endmodule

// File: doc/blood_sprite_engine.md
# blood_sprite_engine

Drives the per-frame blood-splatter ROMs (64×64, 12-bit colour, address registered inside each ROM) and turns their output into an overlay pixel for the VGA pixel pipeline. On a hit trigger it latches the splatter position and plays frames 0..FRAMES-1 in step with video frames. For each scan position it generates ROM row/col and selects the active frame's colour. It outputs a registered colour with an opaque flag to the pixel mixer; black (12'h000) is transparent.

## Interface
- FRAMES, 8: number of animation frames/ROMs (≤ 8).
- FRAME_HOLD, 4: video frames each animation frame is shown (≥ 1).
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- video_on  in  1  scan position is in the visible area.
- x, y  in  10 each  current scan position.
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- trigger  in  1  one-cycle hit pulse.
- hit_x, hit_y  in  10 each  splatter top-left, sampled with trigger.
- rom_row, rom_col  out  6 each  address to all frame ROMs (combinational).
- rom_data  in  FRAMES*12  concatenated ROM outputs; frame k at bits [12k+11:12k].
- rgb_out  out  12  overlay colour (registered).
- blood_on  out  1  rgb_out is opaque and must be drawn (registered).
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, ARMED, PLAY.
  - IDLE: trigger → latch hit_x/hit_y → ARMED.
  - ARMED: frame_tick → PLAY with frame=0 and hold=0.
  - PLAY: on each frame_tick, hold++; when hold reaches FRAME_HOLD-1, reset hold to 0 and increment frame. A frame_tick with frame=FRAMES-1 and hold=FRAME_HOLD-1 → IDLE.
- frame and position change only at frame_tick or trigger, never mid-scan from the counters. This prevents tearing.
- Retrigger in ARMED or PLAY: latch the new position → ARMED. frame and hold are cleared, and output is blanked until the next frame_tick.
- trigger and frame_tick in the same cycle: trigger wins; the state goes to ARMED and the tick is ignored.
- In-box test uses 11-bit arithmetic, so there is no wrap at the right/bottom edge: x ≥ px, x < px+64, y ≥ py, y < py+64.
- rom_col = (x−px)[5:0] and rom_row = (y−py)[5:0]. Outside the box both are 0.
- Opaque is required for a drawn pixel: state=PLAY, video_on, in-box, and the selected colour ≠ 12'h000.
- Reset mid-animation: immediately IDLE with all counters 0 and outputs 0. Latched position is cleared to 0.

## Timing
- Cycle 0: x/y presented; rom_row/rom_col are driven combinationally the same cycle.
- Edge 1:
  - The ROM registers the address, and rom_data is valid during cycle 1.
  - The block registers in-box, video_on, PLAY-state and frame index into stage 1, so the selected frame matches the address.
- Edge 2: rgb_out and blood_on are registered. Total latency from x/y to output is 2 clocks, which the mixer must match.
- When blood_on=0, rgb_out=12'h000.
- The state update from frame_tick takes effect from the next cycle.
- Reset values:
  - rgb_out=0, blood_on=0, busy=0.
  - rom_row=rom_col=0 (the latched position is 0 and the box test fails).
  - state=IDLE.

## Structure
- Package blood_pkg:
  - SPR_SIZE=64, COLOR_W=12, TRANSPARENT=12'h000.
  - State enum {IDLE, ARMED, PLAY}.
  - Frame-index width function.
- Sub-module blood_anim_ctrl: FSM, hold/frame counters and position latch. Outputs frame, px, py, playing.
- Top level: box test, address generation, two-stage pipeline and frame mux.

## Test plan
- Reset asserted mid-PLAY (frame 3) → same cycle: busy=0, rgb_out=0, blood_on=0; after release, frame_tick produces no output.
- trigger at hit (100,50), then frame_tick → x=100,y=50 gives rom_row=0, rom_col=0 in cycle 0. With ROM model data 12'hE00, rgb_out=12'hE00 and blood_on=1 two clocks later.
- FRAMES=8, FRAME_HOLD=4 → frame index steps every 4 ticks; busy drops after the 32nd tick following ARMED.
- Hit at (1000,470) → x=1023 in-box with col 23; x=0 (wrap) is not in-box; y beyond 479 is never drawn.
- Selected ROM data 12'h000 inside box → blood_on=0, rgb_out=0; video_on=0 inside box → blood_on=0.
- Retrigger at frame 5 to (200,200), with trigger and frame_tick in the same cycle → state ARMED, no output. Next tick → frame 0 at (200,200).
